fetch_mem_arbiter: RTL
======================

Name: fetch_mem_arbiter

Overview:
- Shares the single-ported RAM between the instruction-fetch requester (icache side) and the data requester (dcache side) of the pipelined CPU.
- A registered grant FSM serialises requests, with data priority by default.
- Routes address, data and control to RAM, and returns load data and wait/hit handshakes to each requester.
- Sits between the two cache-side requesters and RAM. The fetch stage sees its hit as iwait low.

Parameters:
- STARVE_LIMIT, 4: consecutive data grants allowed while an instruction request waits. Used only with ARB_STARVE_GUARD_EN.
- CNT_W, 3: width of the starvation counter. Must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- CLK  input  1  clock
- nRST  input  1  reset, asynchronous, active-low
- iREN  input  1  instruction read request
- iaddr  input  32  instruction address
- iload  output  32  instruction read data
- iwait  output  1  instruction stall; low for one cycle = hit
- dREN  input  1  data read request
- dWEN  input  1  data write request
- daddr  input  32  data address
- dstore  input  32  data write value
- dload  output  32  data read data
- dwait  output  1  data stall; low for one cycle = hit
- ramREN  output  1  RAM read enable
- ramWEN  output  1  RAM write enable
- ramaddr  output  32  RAM address
- ramstore  output  32  RAM write data
- ramload  input  32  RAM read data
- ramstate  input  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR

Behaviour:
- Reset values:
  - Clocking: CLK, nRST asynchronous active-low.
  - On reset: state IDLE; starvation counter 0.
  - Outputs: iwait=1, dwait=1, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iload=0, dload=0.
- States: IDLE, DGRANT, IGRANT. The state register is the only sequential decision point.
- IDLE:
  - RAM outputs all 0.
  - If dREN|dWEN, next state DGRANT.
  - Else if iREN, next state IGRANT.
  - Else stay IDLE.
- DGRANT (combinational outputs):
  - ramaddr=daddr, ramstore=dstore.
  - ramWEN=dWEN. ramREN=dREN&~dWEN, so WEN wins if both are asserted.
  - dload=ramload.
- IGRANT (combinational outputs):
  - ramaddr=iaddr, ramREN=iREN, ramWEN=0.
  - iload=ramload.
- Completion:
  - In a grant state, ramstate==ACCESS pulls the granted requester's wait low for that cycle only.
  - Next state is IDLE; one idle cycle follows every transfer.
  - Minimum latency is 2 cycles from request to hit (IDLE, then grant with ACCESS). Each BUSY cycle adds one.
- Wait outputs:
  - The non-granted requester's wait stays 1.
  - A requester with no active request sees wait=1. It is ignored by convention.
- BUSY / FREE: hold the grant and keep outputs stable.
- ERROR: treated as retry. Hold the grant with no hit and keep the request asserted to RAM.
- Abort:
  - If the granted requester deasserts its request before ACCESS (fetch squashed by a jump, or a pipeline flush), the RAM enables drop combinationally that cycle.
  - Next state is IDLE and no hit is signalled.
- No preemption: an arriving dREN/dWEN does not interrupt IGRANT.
- Simultaneous requests in IDLE: data is served first, then instruction after the following IDLE cycle.
- Load data (iload/dload):
  - Combinational passthrough of ramload while granted; 0 otherwise.
  - The requester samples on its hit cycle.

Optional Feature:
- Macro: ARB_STARVE_GUARD_EN.
- With the macro defined:
  - The counter increments on each completed data transfer while iREN=1.
  - It clears on an instruction grant or when iREN=0.
  - When the counter equals STARVE_LIMIT and iREN=1, IDLE chooses IGRANT even if a data request is pending.
- Without the macro: strict data priority; no counter is present.

Test Plan:
1. Reset: assert nRST=0 mid-IGRANT -> immediately iwait=1, dwait=1, ramREN=0, ramWEN=0, ramaddr=0; after release, state is IDLE.
2. Fetch: iREN=1, iaddr=0x40; ramstate BUSY for 2 cycles then ACCESS with ramload=0x8C010004 -> ramaddr=0x40, ramREN=1 in IGRANT; iwait low exactly on cycle 4 with iload=0x8C010004.
3. Contention: iREN=1 (iaddr=0x40) and dREN=1 (daddr=0x100) in the same cycle, RAM ACCESS immediately -> ramaddr=0x100, dwait low in cycle 2; IDLE in cycle 3; ramaddr=0x40, iwait low in cycle 4.
4. Write: dWEN=1, daddr=0x200, dstore=0xDEADBEEF (dREN also 1) -> ramWEN=1, ramREN=0, ramstore=0xDEADBEEF; dwait low on ACCESS; ERROR for 1 cycle beforehand only delays the hit by 1 cycle.
5. Abort: iREN drops during IGRANT while ramstate=BUSY -> ramREN=0 that cycle, next state IDLE, iwait never low.
6. Starvation: dREN and iREN held high continuously, RAM always ACCESS -> with ARB_STARVE_GUARD_EN, the instruction is granted after exactly 4 data hits; without it, iwait stays 1 for 50 cycles.

Source files
------------

// File: rtl/fetch_mem_arbiter.sv
// fetch_mem_arbiter
//
// Arbitrates the single-ported RAM between the instruction-fetch requester
// (icache side) and the data requester (dcache side). A registered grant FSM
// (IDLE -> DGRANT/IGRANT -> IDLE) serialises transfers, with data given
// priority. Address, write data and enables are steered to the RAM from the
// granted requester. Load data and the wait/hit handshake go back to that
// requester. A wait output that is low for one cycle signals a hit.
//
// Optional feature (macro ARB_STARVE_GUARD_EN): a starvation counter forces
// an instruction grant after STARVE_LIMIT consecutive data transfers that
// completed while an instruction request was waiting.
//
// Ports:
//   CLK, nRST              clock; asynchronous active-low reset
//   iREN, iaddr            instruction read request and address
//   iload, iwait           instruction read data; stall (low = hit)
//   dREN, dWEN             data read / write request
//   daddr, dstore          data address and write value
//   dload, dwait           data read data; stall (low = hit)
//   ramREN, ramWEN         RAM read / write enables
//   ramaddr, ramstore      RAM address and write data
//   ramload                RAM read data
//   ramstate               RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR
module fetch_mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        iwait,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dwait,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DGRANT = 2'd1;
  localparam logic [1:0] IGRANT = 2'd2;

  localparam logic [1:0] RAM_ACCESS = 2'd2;

  // The counter must be able to hold STARVE_LIMIT.
  if ((2 ** CNT_W) <= STARVE_LIMIT) begin : g_cnt_w_too_narrow
    $error("fetch_mem_arbiter: CNT_W too narrow for STARVE_LIMIT");
  end

  logic [1:0] r_state;
  logic [1:0] w_next;
  logic       w_dreq;
  logic       w_access;
  logic       w_istarve;

  assign w_dreq   = dREN | dWEN;
  assign w_access = (ramstate == RAM_ACCESS);

`ifdef ARB_STARVE_GUARD_EN
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] r_starve_cnt;

  // Counts data transfers completed while a fetch waits. The counter clears
  // once the fetch is granted or withdrawn. It saturates at LIMIT so it
  // cannot wrap past the trigger value.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_starve_cnt <= '0;
    end else if (!iREN || (r_state == IGRANT)) begin
      r_starve_cnt <= '0;
    end else if ((r_state == DGRANT) && w_dreq && w_access &&
                 (r_starve_cnt != LIMIT)) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  assign w_istarve = iREN && (r_starve_cnt == LIMIT);
`else
  assign w_istarve = 1'b0;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // A grant ends on a hit (ACCESS) or when its requester withdraws. An
  // arriving data request never preempts a fetch already granted.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_dreq && !w_istarve) begin
          w_next = DGRANT;
        end else if (iREN) begin
          w_next = IGRANT;
        end
      end
      DGRANT: begin
        if (!w_dreq || w_access) begin
          w_next = IDLE;
        end
      end
      IGRANT: begin
        if (!iREN || w_access) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // The enables follow the live request lines. An abort therefore drops them
  // in the same cycle. BUSY, FREE and ERROR simply hold the grant.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iload    = '0;
    dload    = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    case (r_state)
      DGRANT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        dload    = ramload;
        dwait    = ~(w_dreq & w_access);
      end
      IGRANT: begin
        ramaddr = iaddr;
        ramREN  = iREN;
        iload   = ramload;
        iwait   = ~(iREN & w_access);
      end
      default: ;
    endcase
  end

endmodule
